// File: rtl/icache_fetch_pkg.sv
// Shared types and defaults for the direct-mapped instruction fetch cache.
package icache_fetch_pkg;

  localparam logic [31:0] PC_INITIAL_ADDRESS = 32'h8000_0000;

  localparam int ICACHE_LINES = 16;
  localparam int ICACHE_WORDS = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2
  } icache_state_t;

endpackage

// File: rtl/icache_refill_fsm.sv
// Line refill sequencer: bus request handshake, beat counting and deferred flush.
module icache_refill_fsm
  import icache_fetch_pkg::*;
#(
  parameter int WORDS  = ICACHE_WORDS,
  parameter int ADDR_W = 32,
  localparam int WORD_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss,
  input  logic              flush,
  input  logic [ADDR_W-1:0] miss_line_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  output logic              busy,
  output logic              flush_pending,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              fill_we,
  output logic [WORD_W-1:0] fill_word,
  output logic              tag_we,
  output logic              set_valid,
  output logic              clear_valid
);

  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(WORDS - 1);

  icache_state_t     state_q, state_d;
  logic [WORD_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] line_q, line_d;
  logic              flush_pending_q, flush_pending_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      beat_q          <= '0;
      line_q          <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      line_q          <= line_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  // A flush seen mid-refill suppresses the fill's valid bit and wipes everything on exit.
  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    line_d          = line_q;
    flush_pending_d = flush_pending_q;
    mem_req_valid   = 1'b0;
    fill_we         = 1'b0;
    tag_we          = 1'b0;
    set_valid       = 1'b0;
    clear_valid     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush) clear_valid = 1'b1;
        if (miss) begin
          line_d  = miss_line_addr;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (flush) flush_pending_d = 1'b1;
        if (mem_req_ready) begin
          beat_d  = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (flush) flush_pending_d = 1'b1;
        if (mem_resp_valid) begin
          fill_we = 1'b1;
          if (beat_q == LAST_BEAT) begin
            tag_we          = 1'b1;
            set_valid       = !(flush_pending_q | flush);
            clear_valid     = flush_pending_q | flush;
            flush_pending_d = 1'b0;
            beat_d          = '0;
            state_d         = S_IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign flush_pending = flush_pending_q;
  assign mem_req_addr  = line_q;
  assign fill_word     = beat_q;

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache answering the predictor's PC stream with a
// registered instruction; misses stall the pipeline while one line is refilled.
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int LINES  = ICACHE_LINES,
  parameter int WORDS  = ICACHE_WORDS,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipeline_en,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              fetch_en,
  input  logic              flush,
  output logic [31:0]       inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  output logic              stall,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data
);

  localparam int WORD_W = $clog2(WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int OFF_W  = WORD_W + 2;
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

  logic [WORD_W-1:0] fetch_word;
  logic [IDX_W-1:0]  fetch_idx;
  logic [TAG_W-1:0]  fetch_tag;
  logic              unused_offset;

  assign fetch_word    = fetch_pc[2 +: WORD_W];
  assign fetch_idx     = fetch_pc[OFF_W +: IDX_W];
  assign fetch_tag     = fetch_pc[ADDR_W-1 -: TAG_W];
  assign unused_offset = ^fetch_pc[1:0];

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [TAG_W-1:0] tag_d  [LINES];
  logic [31:0]      data_q [LINES][WORDS];
  logic [31:0]      data_d [LINES][WORDS];

  logic hit, miss;
  assign hit  = fetch_en & valid_q[fetch_idx] & (tag_q[fetch_idx] == fetch_tag);
  assign miss = fetch_en & ~hit;

  logic              busy, flush_pending, fill_we, tag_we, set_valid, clear_valid;
  logic [WORD_W-1:0] fill_word;
  logic [ADDR_W-1:0] miss_line_addr;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;

  assign miss_line_addr = {fetch_tag, fetch_idx, {OFF_W{1'b0}}};
  assign fill_idx       = mem_req_addr[OFF_W +: IDX_W];
  assign fill_tag       = mem_req_addr[ADDR_W-1 -: TAG_W];

  icache_refill_fsm #(
    .WORDS  (WORDS),
    .ADDR_W (ADDR_W)
  ) u_refill (
    .clk            (clk),
    .rst            (rst),
    .miss           (miss),
    .flush          (flush),
    .miss_line_addr (miss_line_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .busy           (busy),
    .flush_pending  (flush_pending),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .fill_we        (fill_we),
    .fill_word      (fill_word),
    .tag_we         (tag_we),
    .set_valid      (set_valid),
    .clear_valid    (clear_valid)
  );

  // A flush pulse also stalls so a same-cycle hit cannot retire from a line being wiped.
  assign stall = busy | miss | flush_pending | flush;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (clear_valid) valid_d = '0;
    else if (set_valid) valid_d[fill_idx] = 1'b1;
    if (tag_we) tag_d[fill_idx] = fill_tag;
    if (fill_we) data_d[fill_idx][fill_word] = mem_resp_data;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  logic [31:0]       inst_out_q, inst_out_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              inst_valid_q, inst_valid_d;

  always_comb begin
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    if (pipeline_en && !stall) begin
      if (hit) begin
        inst_out_d   = data_q[fetch_idx][fetch_word];
        inst_pc_d    = fetch_pc;
        inst_valid_d = 1'b1;
      end else if (!fetch_en) begin
        inst_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_out_q   <= '0;
      inst_pc_q    <= ADDR_W'(PC_INITIAL_ADDRESS);
      inst_valid_q <= 1'b0;
    end else begin
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign inst_out   = inst_out_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: refill, sequential hits, conflicts, flush and reset-abort.
module tb_icache_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipeline_en;
  logic [31:0] fetch_pc;
  logic        fetch_en;
  logic        flush;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        stall;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  int n_checks = 0;
  int n_fail   = 0;

  icache_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .pipeline_en    (pipeline_en),
    .fetch_pc       (fetch_pc),
    .fetch_en       (fetch_en),
    .flush          (flush),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .stall          (stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic en);
    fetch_pc = pc;
    fetch_en = en;
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
    end
  endtask

  // Serves one line refill; flush_beat >= 0 pulses flush alongside that beat.
  task automatic doRefill(input logic [31:0] base, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3,
                          input int ready_delay, input int flush_beat);
    logic [31:0] words [4];
    int wait_cnt;
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
    wait_cnt = 0;
    while (!mem_req_valid && wait_cnt < 10) begin
      step();
      wait_cnt++;
    end
    checkOutput("req_valid", {31'd0, mem_req_valid}, 32'd1);
    for (int i = 0; i < ready_delay; i++) begin
      checkOutput("req_addr_held", mem_req_addr, base);
      checkOutput("stall_req", {31'd0, stall}, 32'd1);
      step();
    end
    checkOutput("req_addr", mem_req_addr, base);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    checkOutput("req_dropped", {31'd0, mem_req_valid}, 32'd0);
    for (int b = 0; b < 4; b++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = words[b];
      flush          = (b == flush_beat);
      checkOutput("stall_fill", {31'd0, stall}, 32'd1);
      step();
    end
    mem_resp_valid = 1'b0;
    flush          = 1'b0;
  endtask

  initial begin
    logic [31:0] seq_data [3];
    seq_data[0] = 32'h22; seq_data[1] = 32'h33; seq_data[2] = 32'h44;

    rst = 1'b1; pipeline_en = 1'b1; fetch_pc = '0; fetch_en = 1'b0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    step();
    step();
    checkOutput("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("rst_inst_out", inst_out, 32'd0);
    checkOutput("rst_inst_pc", inst_pc, 32'h8000_0000);
    checkOutput("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    rst = 1'b0;
    applyStimulus(32'h0, 1'b0);
    checkOutput("idle_stall", {31'd0, stall}, 32'd0);

    // Cold miss with a two-cycle ready delay
    applyStimulus(32'h8000_0000, 1'b1);
    checkOutput("cold_miss_stall", {31'd0, stall}, 32'd1);
    doRefill(32'h8000_0000, 32'h11, 32'h22, 32'h33, 32'h44, 2, -1);
    checkOutput("after_fill_stall", {31'd0, stall}, 32'd0);
    checkOutput("no_update_in_stall", {31'd0, inst_valid}, 32'd0);
    step();
    checkOutput("first_inst", inst_out, 32'h11);
    checkOutput("first_pc", inst_pc, 32'h8000_0000);
    checkOutput("first_valid", {31'd0, inst_valid}, 32'd1);

    // Sequential hits on the resident line
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h8000_0004 + 32'(4 * i), 1'b1);
      checkOutput("seq_stall", {31'd0, stall}, 32'd0);
      checkOutput("seq_no_req", {31'd0, mem_req_valid}, 32'd0);
      step();
      checkOutput("seq_inst", inst_out, seq_data[i]);
      checkOutput("seq_pc", inst_pc, 32'h8000_0004 + 32'(4 * i));
    end

    // pipeline_en low holds outputs; fetch_en low drops inst_valid
    pipeline_en = 1'b0;
    applyStimulus(32'h8000_0000, 1'b1);
    step();
    checkOutput("hold_inst", inst_out, 32'h44);
    pipeline_en = 1'b1;
    applyStimulus(32'h8000_0000, 1'b0);
    step();
    checkOutput("bubble_valid", {31'd0, inst_valid}, 32'd0);

    // Conflict miss on the same index, then back again
    applyStimulus(32'h8000_0100, 1'b1);
    checkOutput("conflict_stall", {31'd0, stall}, 32'd1);
    doRefill(32'h8000_0100, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1, -1);
    step();
    checkOutput("conflict_inst", inst_out, 32'hA0);
    applyStimulus(32'h8000_0000, 1'b1);
    checkOutput("return_miss", {31'd0, stall}, 32'd1);
    doRefill(32'h8000_0000, 32'h11, 32'h22, 32'h33, 32'h44, 0, -1);
    step();
    checkOutput("return_inst", inst_out, 32'h11);

    // Flush while idle, coincident with a hit
    flush = 1'b1;
    applyStimulus(32'h8000_0004, 1'b1);
    checkOutput("flush_hit_stall", {31'd0, stall}, 32'd1);
    step();
    flush = 1'b0;
    checkOutput("flush_no_update", inst_pc, 32'h8000_0000);
    applyStimulus(32'h8000_0004, 1'b1);
    checkOutput("post_flush_miss", {31'd0, stall}, 32'd1);
    step();
    checkOutput("post_flush_req", {31'd0, mem_req_valid}, 32'd1);
    doRefill(32'h8000_0000, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 0, -1);
    step();
    checkOutput("post_flush_inst", inst_out, 32'hB1);

    // Flush during the second fill beat
    applyStimulus(32'h8000_0200, 1'b1);
    doRefill(32'h8000_0200, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 0, 1);
    checkOutput("fill_flush_miss", {31'd0, stall}, 32'd1);
    checkOutput("fill_flush_hold", inst_out, 32'hB1);
    step();
    checkOutput("fill_flush_req", {31'd0, mem_req_valid}, 32'd1);
    doRefill(32'h8000_0200, 32'hD0, 32'hD1, 32'hD2, 32'hD3, 0, -1);
    step();
    checkOutput("refetch_inst", inst_out, 32'hD0);
    checkOutput("refetch_pc", inst_pc, 32'h8000_0200);

    // Reset in the middle of a fill
    applyStimulus(32'h8000_0300, 1'b1);
    step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hDEAD_0000;
    step();
    rst = 1'b1;
    applyStimulus(32'h8000_0300, 1'b0);
    step();
    rst = 1'b0;
    #2;
    checkOutput("abort_req_valid", {31'd0, mem_req_valid}, 32'd0);
    checkOutput("abort_inst_valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("abort_idle_stall", {31'd0, stall}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      mem_resp_data = 32'hBAD0_0000 + 32'(i);
      step();
      checkOutput("stray_no_req", {31'd0, mem_req_valid}, 32'd0);
    end
    mem_resp_valid = 1'b0;
    applyStimulus(32'h8000_0300, 1'b1);
    checkOutput("abort_refetch_miss", {31'd0, stall}, 32'd1);
    doRefill(32'h8000_0300, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 1, -1);
    applyStimulus(32'h8000_030C, 1'b1);
    step();
    checkOutput("abort_line_word3", inst_out, 32'hE3);
    applyStimulus(32'h8000_0200, 1'b1);
    checkOutput("reset_cleared_valid", {31'd0, stall}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped instruction cache; the responder for the PC stream the branch predictor issues.
- Each cycle it accepts the combinational fetch PC and returns the 32-bit instruction, registered, to the decode stage.
- On a miss it holds the pipeline via `stall`, refills one line from the memory bus word by word, then replays the lookup.
- Also services a whole-cache invalidate (fence.i / reset of code memory).

Parameters:
- LINES, 16, number of cache lines (power of 2, ≥2)
- WORDS, 4, 32-bit words per line (power of 2, ≥2)
- ADDR_W, 32, address width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- pipeline_en  in  1  global pipeline advance; output register updates only when high
- fetch_pc  in  32  PC to fetch; comb from predictor, word aligned
- fetch_en  in  1  PC is a real request; low during reset/bubble
- flush  in  1  invalidate all lines (single-cycle pulse)
- inst_out  out  32  instruction for decode stage
- inst_pc  out  32  PC matching inst_out
- inst_valid  out  1  inst_out holds a fetched instruction
- stall  out  1  comb; pipeline control must drop pipeline_en while high
- mem_req_valid  out  1  refill request valid
- mem_req_addr  out  32  line-aligned refill base address
- mem_req_ready  in  1  bus accepted request
- mem_resp_valid  in  1  one refill word valid
- mem_resp_data  in  32  refill word; beats arrive in ascending order

Behaviour:
- Address split: offset = pc[1:0] (ignored); word = next log2(WORDS) bits; index = next log2(LINES) bits; tag = remaining upper bits.
- Storage: valid bit, tag and WORDS×32 data per line, all flops. Only the valid bits are reset.
- hit = fetch_en & valid[index] & (tag_arr[index] == tag).
- stall = (state != S_IDLE) | (fetch_en & !hit) | flush_pending.
- States:
  - S_IDLE: no refill in progress.
    - fetch_en & miss → latch line address {tag, index, 0}, go to S_REQ.
  - S_REQ: mem_req_valid=1, mem_req_addr = latched line address, held stable until mem_req_ready.
    - Handshake (valid & ready) → S_FILL, beat counter = 0.
  - S_FILL: each mem_resp_valid writes the word at the beat counter, counter +1.
    - On beat WORDS-1: write tag, set valid → S_IDLE.
    - The lookup replays next cycle; it now hits.
- Output register, hit latency 1:
  - At posedge with pipeline_en & !stall & hit: inst_out <= data, inst_pc <= fetch_pc, inst_valid <= 1.
  - pipeline_en & !stall & !fetch_en: inst_valid <= 0.
  - pipeline_en low: hold all outputs.
- Reset:
  - state = S_IDLE; all valid = 0; inst_valid = 0, inst_out = 0, inst_pc = `PC_INITIAL_ADDRESS`.
  - mem_req_valid = 0; counter = 0.
  - Reset mid-refill abandons it; no valid bit is set; late mem_resp beats are ignored in S_IDLE.
- Flush:
  - In S_IDLE: clears all valid bits at that edge.
  - In S_REQ/S_FILL: sets flush_pending; the refill completes but its valid bit is NOT set; valid bits are cleared when returning to S_IDLE.
  - Flush and hit in the same cycle: stall high, no output update.
- fetch_pc may change during a refill (predictor redirect via id_invalid):
  - The refill still finishes for the latched line.
  - In S_IDLE the new PC is looked up; a miss starts a fresh refill.
- mem_resp_valid outside S_FILL: ignored.
- Beat counter wraps only via the state exit; never exceeds WORDS-1.
- Tag compare uses full upper bits, so there is no aliasing between lines.

Decomposition:
- Shared `defs.sv` holds:
  - `PC_INITIAL_ADDRESS`
  - state localparams S_IDLE/S_REQ/S_FILL as a 2-bit enum typedef `icache_state_t`
  - `ICACHE_LINES` / `ICACHE_WORDS` defaults
- One natural sub-module: `icache_refill_fsm`. It covers the state register, beat counter, request handshake and flush_pending, and emits write-enable, word index and tag-write strobes.
- Arrays and the output register stay in the top level.

Test Plan:
- Reset, fetch_en=1, fetch_pc=0x8000_0000, memory returns 0x11,0x22,0x33,0x44 after 2-cycle ready delay:
  - stall high until the beat-4 cycle completes.
  - Next enabled edge: inst_out=0x11, inst_pc=0x8000_0000, inst_valid=1.
  - mem_req_addr=0x8000_0000 held stable while ready=0.
- Sequential fetch 0x8000_0004/08/0C after that refill: three hits, one per cycle, inst_out 0x22/0x33/0x44, stall never asserted, no mem_req_valid.
- Conflict miss at 0x8000_0100 (same index, different tag):
  - Refill occurs.
  - Returning to 0x8000_0000 misses again and refills.
- Flush pulse while idle with line resident: next fetch of 0x8000_0000 misses and issues mem_req_valid.
- Flush during S_FILL beat 2: refill completes, the line is not valid afterwards, and the re-fetch misses.
- rst asserted during S_FILL:
  - Next cycle: state S_IDLE, mem_req_valid=0, inst_valid=0.
  - Stray mem_resp_valid beats do not alter any line.
  - Fetching the same PC misses.
